// File: rtl/audio_pkg.sv
// Shared constants for the chiptune generator: default parameters, note half-periods
// (in 25.175 MHz pixel-clock cycles) and the 16-step tune.
package audio_pkg;

  localparam int PWM_BITS_DEF    = 8;
  localparam int NOTE_FRAMES_DEF = 8;
  localparam int SEQ_LEN_DEF     = 16;
  localparam int VOL_DECAY_DEF   = 16;

  localparam logic [15:0] HP_REST = 16'd0;
  localparam logic [15:0] HP_C4   = 16'd48112;
  localparam logic [15:0] HP_E4   = 16'd38183;
  localparam logic [15:0] HP_G4   = 16'd32107;
  localparam logic [15:0] HP_C5   = 16'd24056;

  // A half-period of 0 marks a rest step.
  function automatic logic [15:0] note_rom(input logic [3:0] idx);
    logic [15:0] half;
    case (idx)
      4'd0:    half = HP_C4;
      4'd1:    half = HP_E4;
      4'd2:    half = HP_G4;
      4'd3:    half = HP_C5;
      4'd4:    half = HP_G4;
      4'd5:    half = HP_E4;
      4'd6:    half = HP_C4;
      4'd7:    half = HP_REST;
      4'd8:    half = HP_E4;
      4'd9:    half = HP_G4;
      4'd10:   half = HP_C5;
      4'd11:   half = HP_REST;
      4'd12:   half = HP_C5;
      4'd13:   half = HP_G4;
      4'd14:   half = HP_E4;
      default: half = HP_REST;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/audio_synth_pwm_dac.sv
// 1-bit PWM DAC: free-running counter, sample latched only at period wrap so the
// duty cycle never changes mid-period, and a mute gate on the registered output.
module audio_pwm_dac #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] sample,
  input  logic                mute,
  output logic                audio_pwm
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] sample_q, sample_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    sample_d  = (pwm_cnt_q == '1) ? sample : sample_q;
    pwm_d     = ~mute & (pwm_cnt_q < sample_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      sample_q  <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sample_q  <= sample_d;
      pwm_q     <= pwm_d;
    end
  end

  assign audio_pwm = pwm_q;

endmodule

// File: rtl/audio_synth.sv
// Frame-locked chiptune generator: v_sync-paced step sequencer, square-wave oscillator
// and per-frame decaying volume envelope, feeding the PWM DAC.
module audio_synth
  import audio_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int NOTE_FRAMES = NOTE_FRAMES_DEF,
  parameter int SEQ_LEN     = SEQ_LEN_DEF,
  parameter int VOL_DECAY   = VOL_DECAY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       mute,
  output logic       audio_pwm,
  output logic [3:0] note_idx
);

  localparam int FC_W = (NOTE_FRAMES > 1) ? $clog2(NOTE_FRAMES) : 1;
  localparam logic [FC_W-1:0]     LAST_FRAME = FC_W'(NOTE_FRAMES - 1);
  localparam logic [3:0]          LAST_STEP  = 4'(SEQ_LEN - 1);
  localparam logic [PWM_BITS-1:0] DECAY      = PWM_BITS'(VOL_DECAY);

  logic                vsync_q, vsync_d;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [3:0]          note_idx_q, note_idx_d;
  logic [PWM_BITS-1:0] volume_q, volume_d;
  logic [15:0]         tone_cnt_q, tone_cnt_d;
  logic                square_q, square_d;
  logic                frame_tick, step_change;
  logic [15:0]         half;
  logic [PWM_BITS-1:0] sample;

  always_comb begin
    vsync_d     = v_sync;
    frame_tick  = vsync_q & ~v_sync;
    step_change = frame_tick && (frame_cnt_q == LAST_FRAME);
    half        = note_rom(note_idx_q);

    frame_cnt_d = frame_cnt_q;
    note_idx_d  = note_idx_q;
    volume_d    = volume_q;
    if (step_change) begin
      frame_cnt_d = '0;
      note_idx_d  = (note_idx_q == LAST_STEP) ? 4'd0 : note_idx_q + 4'd1;
      volume_d    = '1;
    end else if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      volume_d    = (volume_q < DECAY) ? '0 : volume_q - DECAY;
    end

    // A new step always starts from a clean low phase, even if a toggle was due.
    tone_cnt_d = tone_cnt_q + 16'd1;
    square_d   = square_q;
    if (step_change || half == 16'd0) begin
      tone_cnt_d = '0;
      square_d   = 1'b0;
    end else if (tone_cnt_q == half - 16'd1) begin
      tone_cnt_d = '0;
      square_d   = ~square_q;
    end

    sample = square_q ? volume_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      frame_cnt_q <= '0;
      note_idx_q  <= '0;
      volume_q    <= '1;
      tone_cnt_q  <= '0;
      square_q    <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      frame_cnt_q <= frame_cnt_d;
      note_idx_q  <= note_idx_d;
      volume_q    <= volume_d;
      tone_cnt_q  <= tone_cnt_d;
      square_q    <= square_d;
    end
  end

  audio_pwm_dac #(.PWM_BITS(PWM_BITS)) u_dac (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .mute      (mute),
    .audio_pwm (audio_pwm)
  );

  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_audio_synth.sv
// Bench for audio_synth: cycle-level reference model of the tune, envelope and PWM
// feeding an expected-output queue, checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_audio_synth;

  localparam int W           = 5;
  localparam int NOTE_FRAMES = 8;
  localparam int SEQ_LEN     = 16;
  localparam int VOL_DECAY   = 16;
  localparam int C4_HALF     = 48112;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_sync = 1'b1;
  logic       mute = 1'b0;
  logic       audio_pwm;
  logic [3:0] note_idx;

  audio_synth dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .v_sync    (v_sync),
    .mute      (mute),
    .audio_pwm (audio_pwm),
    .note_idx  (note_idx)
  );

  always #5 clk = ~clk;

  // The tune, as half-periods in clock cycles (0 = rest).
  int tune [16] = '{48112, 38183, 32107, 24056, 32107, 38183, 48112, 0,
                    38183, 32107, 24056, 0, 24056, 32107, 38183, 0};

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model state: step, frames into the step, volume, cycles since step start,
  // cycles since reset (PWM phase), latched duty, previous v_sync.
  int m_step, m_frames, m_vol, m_elapsed, m_cyc, m_sample;
  bit m_vs_prev;

  task automatic model_reset();
    m_step = 0; m_frames = 0; m_vol = 255; m_elapsed = 0;
    m_cyc = 0; m_sample = 0; m_vs_prev = 1'b1;
  endtask

  function automatic bit m_square();
    int half;
    half = tune[m_step];
    if (half == 0) return 1'b0;
    return ((m_elapsed / half) % 2) == 1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Advance one clock with the current inputs; push the expected outputs first.
  task automatic tick();
    bit pwm;
    if (!rst_n) begin
      model_reset();
      pwm = 1'b0;
    end else begin
      pwm = !mute && ((m_cyc % 256) < m_sample);
      if (m_cyc % 256 == 255) m_sample = m_square() ? m_vol : 0;
      if (m_vs_prev && !v_sync) begin
        if (m_frames == NOTE_FRAMES - 1) begin
          m_frames = 0; m_step = (m_step + 1) % SEQ_LEN; m_vol = 255; m_elapsed = 0;
        end else begin
          m_frames++; m_vol = (m_vol < VOL_DECAY) ? 0 : m_vol - VOL_DECAY; m_elapsed++;
        end
      end else begin
        m_elapsed++;
      end
      m_vs_prev = v_sync;
      m_cyc++;
    end
    exp_q.push_back({pwm, 4'(m_step)});
    @(posedge clk);
    #1;
  endtask

  task automatic align_window();
    while (m_cyc % 256 != 0) tick();
  endtask

  task automatic count_window(output int cnt);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (audio_pwm) cnt++;
    end
  endtask

  task automatic frame_edge();
    v_sync = 1'b0; tick();
    v_sync = 1'b1; tick();
  endtask

  // Monitor: every output cycle is compared against the oldest expectation.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({audio_pwm, note_idx} !== e) begin
          n_fail++;
          $display("FAIL out_cycle t=%0t: got pwm=%0b note=%0d expected pwm=%0b note=%0d",
                   $time, audio_pwm, note_idx, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int edges, cnt, ph, lo_ticks, hi_ticks;
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_pwm", int'(audio_pwm), 0);
    check("reset_note", int'(note_idx), 0);
    rst_n = 1'b1;

    // Random frame pacing through 127 frame edges, with random mute.
    edges = 0;
    while (edges < SEQ_LEN * NOTE_FRAMES - 1) begin
      mute = 1'($urandom_range(0, 1));
      lo_ticks = $urandom_range(1, 2);
      hi_ticks = $urandom_range(1, 3);
      v_sync = 1'b0;
      tick();
      edges++;
      check("step_after_edges", int'(note_idx), (edges / NOTE_FRAMES) % SEQ_LEN);
      for (int i = 1; i < lo_ticks; i++) tick();
      v_sync = 1'b1;
      for (int i = 0; i < hi_ticks; i++) tick();
    end
    mute = 1'b0;

    // Final edge wraps 15 -> 0, phased so the first C4 toggle lands exactly on a duty latch.
    ph = ((255 - (C4_HALF + 1)) % 256 + 256) % 256;
    while (m_cyc % 256 != ph) tick();
    v_sync = 1'b0; tick();
    check("wrap_to_0", int'(note_idx), 0);
    v_sync = 1'b1;

    // Hold the C4 step until the square is high and latched.
    repeat (C4_HALF + 300) tick();
    align_window();
    count_window(cnt);
    check("c4_full_duty", cnt, 255);
    count_window(cnt);
    check("c4_full_duty_2", cnt, 255);

    // Three frame ticks within the step: 255 - 3*16.
    repeat (3) frame_edge();
    repeat (256) tick();
    align_window();
    count_window(cnt);
    check("decay_duty", cnt, 207);

    // Mute for 50 cycles in the middle of the high part of a window.
    align_window();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mute = (i >= 100 && i < 150);
      tick();
      if (audio_pwm) cnt++;
      if (i == 100) check("mute_next_cycle", int'(audio_pwm), 0);
    end
    mute = 1'b0;
    check("mute_window", cnt, 207 - 50);
    count_window(cnt);
    check("unmute_duty", cnt, 207);

    // Run to step 3, then assert reset between clock edges.
    repeat (3 * NOTE_FRAMES) frame_edge();
    check("at_step3", int'(note_idx), 3);
    repeat (37) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(audio_pwm), 0);
    check("async_rst_note", int'(note_idx), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Random v_sync / mute activity after reset.
    for (int i = 0; i < 3000; i++) begin
      v_sync = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mute = ~mute;
      tick();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
